// File: rtl/comm_pkg.sv
// Shared types and opcode constants for the copter-side command link.
package comm_pkg;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } frame_state_t;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART receiver and transmitter sharing one baud divisor; LSB first.
//  rx state | meaning
//  R_IDLE   | line idle, waiting for a low level
//  R_START  | timing to mid start bit, confirm it is still low
//  R_DATA   | sampling 8 data bits at mid-bit
//  R_STOP   | sampling stop bit; low means framing error
//  R_BREAK  | after framing error, wait for line high before re-arming
//  tx state | meaning
//  T_IDLE   | TX held high, accepts trmt
//  T_SEND   | shifting start, 8 data, stop bits
module uart_trx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic       rx_err,
  output logic [7:0] rx_data
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd3;
  localparam logic [2:0] R_BREAK = 3'd4;

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_SEND = 1'b1;

  logic          rx_meta, rx_sync;
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
      rx_err   <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_rdy  <= 1'b0;
      rx_err  <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (!rx_sync) begin
            rx_cnt   <= HALF;
            rx_state <= R_START;
          end
        end
        R_BREAK: begin
          if (rx_sync) rx_state <= R_IDLE;
        end
        default: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CW'(1);
          end else begin
            rx_cnt <= FULL;
            case (rx_state)
              R_START: begin
                rx_bits  <= '0;
                rx_state <= rx_sync ? R_IDLE : R_DATA;
              end
              R_DATA: begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bits  <= rx_bits + 3'd1;
                if (rx_bits == 3'd7) rx_state <= R_STOP;
              end
              default: begin
                if (rx_sync) begin
                  rx_rdy   <= 1'b1;
                  rx_data  <= rx_shift;
                  rx_state <= R_IDLE;
                end else begin
                  rx_err   <= 1'b1;
                  rx_state <= R_BREAK;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  logic [0:0]    tx_state;
  logic [8:0]    tx_shift;
  logic [3:0]    tx_left;
  logic [CW-1:0] tx_cnt;

  assign tx_busy = (tx_state == T_SEND);

  // tx_left counts bits still to go after the one currently on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      tx_shift <= '1;
      tx_left  <= '0;
      tx_cnt   <= '0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == T_IDLE) begin
        if (trmt) begin
          tx       <= 1'b0;
          tx_shift <= {1'b1, tx_data};
          tx_left  <= 4'd9;
          tx_cnt   <= FULL;
          tx_state <= T_SEND;
        end
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CW'(1);
      end else if (tx_left == 4'd0) begin
        tx       <= 1'b1;
        tx_done  <= 1'b1;
        tx_state <= T_IDLE;
      end else begin
        tx       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_left  <= tx_left - 4'd1;
        tx_cnt   <= FULL;
      end
    end
  end

endmodule

// File: rtl/comm_slave.sv
// Copter end of the command link: assembles 3-byte command frames from UART RX
// and sends a 1-byte response on UART TX.
//  state    | meaning
//  WAIT_CMD | expecting opcode byte
//  WAIT_HI  | opcode held, expecting data[15:8]
//  WAIT_LO  | opcode and high byte held, expecting data[7:0]
module comm_slave
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int FRAME_TO = 1 << 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_ovr,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int TW = $clog2(FRAME_TO + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(FRAME_TO - 1);

  logic         rx_rdy, rx_err;
  logic [7:0]   rx_data;
  frame_state_t state;
  logic [7:0]   shadow_cmd, shadow_hi;
  logic [TW-1:0] to_cnt;
  logic         frame_done;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) trx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .trmt    (send_resp),
    .tx_data (resp),
    .tx      (TX),
    .tx_busy (tx_busy),
    .tx_done (resp_sent),
    .rx_rdy  (rx_rdy),
    .rx_err  (rx_err),
    .rx_data (rx_data)
  );

  assign frame_done = rx_rdy && (state == WAIT_LO);

  // Timeout is reloaded on every accepted byte and parked while waiting for an opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_CMD;
      shadow_cmd <= '0;
      shadow_hi  <= '0;
      to_cnt     <= TO_LOAD;
    end else begin
      if (rx_err) begin
        state <= WAIT_CMD;
      end else if (rx_rdy) begin
        case (state)
          WAIT_CMD: begin
            shadow_cmd <= rx_data;
            state      <= WAIT_HI;
          end
          WAIT_HI: begin
            shadow_hi <= rx_data;
            state     <= WAIT_LO;
          end
          default: state <= WAIT_CMD;
        endcase
      end else if (state != WAIT_CMD && to_cnt == '0) begin
        state <= WAIT_CMD;
      end
      if (rx_rdy || state == WAIT_CMD) to_cnt <= TO_LOAD;
      else if (to_cnt != '0)           to_cnt <= to_cnt - TW'(1);
    end
  end

  // A completing frame takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
      cmd_ovr <= 1'b0;
    end else if (frame_done) begin
      cmd     <= shadow_cmd;
      data    <= {shadow_hi, rx_data};
      cmd_rdy <= 1'b1;
      if (cmd_rdy && !clr_cmd_rdy) cmd_ovr <= 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comm_slave.sv
// Directed plus randomized bench for comm_slave with a byte-level frame model.
module tb_comm_slave;
  import comm_pkg::*;

  localparam int BAUD = 16;
  localparam int FTO  = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        cmd_ovr;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  int errors = 0;
  int checks = 0;

  // reference model: byte position in frame plus output image
  int          m_cnt;
  logic [7:0]  m_sc, m_sh, m_cmd;
  logic [15:0] m_data;
  logic        m_rdy, m_ovr;

  comm_slave #(.BAUD_DIV(BAUD), .FRAME_TO(FTO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_ovr     (cmd_ovr),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_sc = '0; m_sh = '0; m_cmd = '0; m_data = '0; m_rdy = 1'b0; m_ovr = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok, input bit clr_co);
    if (!ok) begin
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      m_sc = b; m_cnt = 1;
    end else if (m_cnt == 1) begin
      m_sh = b; m_cnt = 2;
    end else begin
      if (m_rdy && !clr_co) m_ovr = 1'b1;
      m_cmd = m_sc; m_data = {m_sh, b}; m_rdy = 1'b1; m_cnt = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".cmd"},     cmd,     m_cmd);
    check({tag, ".data"},    data,    m_data);
    check({tag, ".cmd_rdy"}, cmd_rdy, m_rdy);
    check({tag, ".cmd_ovr"}, cmd_ovr, m_ovr);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk); RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = stop_ok;
    repeat (BAUD) @(negedge clk);
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(b, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
    send_good(c);
    send_good(d[15:8]);
    send_good(d[7:0]);
  endtask

  task automatic do_clr();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n > FTO) m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic tx_check(input string tag, input logic [7:0] val, input bit poke);
    int busy_cnt, pulses, w;
    logic [7:0] got;
    logic start_lo, stop_hi;
    busy_cnt = 0; pulses = 0; got = '0; start_lo = 1'b0; stop_hi = 1'b0;
    @(negedge clk); resp = val; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0; resp = ~val;
    fork
      begin
        while (tx_busy === 1'b1 && busy_cnt < 12 * BAUD) begin
          busy_cnt++;
          if (resp_sent === 1'b1) pulses++;
          @(negedge clk);
        end
        repeat (3) begin
          if (resp_sent === 1'b1) pulses++;
          @(negedge clk);
        end
      end
      begin
        w = 0;
        while (TX !== 1'b0 && w < 4 * BAUD) begin @(negedge clk); w++; end
        repeat (BAUD / 2) @(negedge clk);
        start_lo = (TX === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          got[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        stop_hi = (TX === 1'b1);
      end
      begin
        if (poke) begin
          repeat (3 * BAUD) @(negedge clk);
          resp = 8'h3C; send_resp = 1'b1;
          @(negedge clk); send_resp = 1'b0;
        end
      end
    join
    check({tag, ".start"},  start_lo, 1'b1);
    check({tag, ".byte"},   got,      val);
    check({tag, ".stop"},   stop_hi,  1'b1);
    check({tag, ".busy"},   busy_cnt, 10 * BAUD);
    check({tag, ".pulses"}, pulses,   1);
    repeat (2 * BAUD) @(negedge clk);
    check({tag, ".idle_busy"}, tx_busy, 1'b0);
    check({tag, ".idle_tx"},   TX,      1'b1);
  endtask

  initial begin
    bit seen;
    logic [7:0]  rc;
    logic [15:0] rd;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.tx", TX, 1'b1);
    check("rst.tx_busy", tx_busy, 1'b0);
    check("rst.resp_sent", resp_sent, 1'b0);
    check_outputs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic frame and clear
    send_frame(SET_PTCH, 16'h003A);
    check_outputs("t1");
    do_clr();
    check_outputs("t1.clr");

    // response transmit, second strobe mid-byte ignored
    tx_check("t2.ack", POS_ACK, 1'b1);
    tx_check("t2.rnd", 8'($urandom), 1'b0);

    // partial frame dropped by timeout, then a clean frame
    send_good(SET_THRST);
    send_good(8'h01);
    idle(FTO + 50);
    check_outputs("t3.partial");
    send_frame(SET_YAW, 16'h800A);
    check_outputs("t3");
    do_clr();
    send_good(CALIBRATE);
    idle(FTO / 2);
    send_good(8'h12);
    send_good(8'h34);
    check_outputs("t3.slowgap");

    // overrun
    do_clr();
    send_frame(SET_PTCH, 16'h0011);
    send_frame(SET_ROLL, 16'h0022);
    check_outputs("t4");

    // clear coincident with completion
    do_reset();
    send_frame(REQ_BATT, 16'h1234);
    send_good(EMER_LAND);
    send_good(8'h00);
    seen = 1'b0;
    fork
      send_byte(8'h00, 1'b1);
      begin
        for (int i = 0; i < 12 * BAUD && !seen; i++) begin
          @(negedge clk);
          if (dut.frame_done === 1'b1) begin
            seen = 1'b1;
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
          end
        end
      end
    join
    check("t5.sync", seen, 1'b1);
    model_byte(8'h00, 1'b1, seen);
    check_outputs("t5");

    // framing error on high byte
    do_clr();
    send_good(REQ_BATT);
    send_byte(8'h5A, 1'b0);
    model_byte(8'h5A, 1'b0, 1'b0);
    check("t6.state", dut.state, WAIT_CMD);
    check_outputs("t6.err");
    send_frame(REQ_BATT, 16'h0000);
    check_outputs("t6");

    // random frames with random clears
    for (int k = 0; k < 6; k++) begin
      rc = 8'($urandom_range(1, 8));
      rd = 16'($urandom);
      send_frame(rc, rd);
      check_outputs($sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) do_clr();
    end
    send_frame(MTRS_OFF, 16'hBEEF);
    check_outputs("rnd.last");

    // reset during a transmit and mid-frame
    send_good(SET_ROLL);
    @(negedge clk); resp = 8'h00; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    check("rst_tx.pre", TX, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_tx.tx", TX, 1'b1);
    check("rst_tx.busy", tx_busy, 1'b0);
    model_reset();
    check_outputs("rst_tx");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(SET_ROLL, 16'h0102);
    check_outputs("rst_tx.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
